// File: rtl/nvram_xfer_ctrl_pkg.sv
// Shared types and constants for the NVRAM upload/download return path of the data_io link.
package nvram_xfer_ctrl_pkg;

  localparam int unsigned IOCTL_AW = 25;
  localparam int unsigned NVX_AW   = 10;
  localparam logic [7:0]  DIN_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StPause,
    StReady,
    StAccess
  } nvx_state_t;

  typedef struct packed {
    logic [NVX_AW-1:0] addr;
    logic              we;
    logic [7:0]        data;
  } nvx_req_t;

  function automatic logic addr_in_range(input logic [IOCTL_AW-1:0] addr,
                                         input int unsigned size);
    return addr < IOCTL_AW'(size);
  endfunction

endpackage

// File: rtl/nvram_xfer_ctrl.sv
// Converts data_io ioctl_rd/ioctl_wr strobes into req/ack accesses on a spare NVRAM port,
// holding the core paused for the duration of an NVRAM image transfer.
module nvram_xfer_ctrl
  import nvram_xfer_ctrl_pkg::*;
#(
  parameter logic [7:0]  NV_INDEX = 8'h04,
  parameter int unsigned AW       = NVX_AW,
  parameter int unsigned NV_SIZE  = 1024
) (
  input  logic                clk_72,
  input  logic                reset,
  input  logic                ioctl_upload,
  input  logic                ioctl_downl,
  input  logic [7:0]          ioctl_index,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic                ioctl_rd,
  input  logic                ioctl_wr,
  input  logic [7:0]          ioctl_dout,
  output logic [7:0]          ioctl_din,
  output logic                pause_req,
  input  logic                pause_ack,
  output logic [AW-1:0]       nv_addr,
  output logic                nv_we,
  output logic [7:0]          nv_wdata,
  output logic                nv_req,
  input  logic                nv_ack,
  input  logic [7:0]          nv_rdata,
  output logic                busy,
  output logic                overflow
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [7:0]    data;
  } req_t;

  nvx_state_t state_q, state_d;
  logic       buf_valid_q, buf_valid_d;
  req_t       buf_q, buf_d;
  req_t       cmd_q, cmd_d;
  logic [7:0] din_q, din_d;
  logic       overflow_q, overflow_d;

  logic active, wr_sel, rd_sel, in_range, strobe_ok, oor_rd, issue;

  always_comb begin
    active    = (ioctl_upload | ioctl_downl) & (ioctl_index == NV_INDEX);
    // Simultaneous strobes: write wins only during a download.
    wr_sel    = ioctl_wr & (~ioctl_rd | ioctl_downl);
    rd_sel    = ioctl_rd & ~wr_sel;
    in_range  = addr_in_range(ioctl_addr, NV_SIZE);
    strobe_ok = active & (wr_sel | rd_sel) & in_range;
    oor_rd    = active & rd_sel & ~in_range;
    issue     = (state_q == StReady) & buf_valid_q;
  end

  // State register
  always_ff @(posedge clk_72) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (active) state_d = StPause;
      StPause: begin
        if (!active && !buf_valid_q) state_d = StIdle;
        else if (pause_ack)          state_d = StReady;
      end
      StReady: begin
        if (buf_valid_q)  state_d = StAccess;
        else if (!active) state_d = StIdle;
      end
      StAccess: if (nv_ack) state_d = StReady;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    pause_req = (state_q != StIdle);
    nv_req    = (state_q == StAccess);
    busy      = buf_valid_q | (state_q == StAccess);
  end

  assign nv_addr   = cmd_q.addr;
  assign nv_we     = cmd_q.we;
  assign nv_wdata  = cmd_q.data;
  assign ioctl_din = din_q;
  assign overflow  = overflow_q;

  // Pending buffer, issued command and read-back datapath
  always_comb begin
    buf_valid_d = buf_valid_q & ~issue;
    buf_d       = buf_q;
    cmd_d       = issue ? buf_q : cmd_q;
    din_d       = din_q;
    overflow_d  = overflow_q;

    // The buffer slot frees on issue, so a strobe in that same cycle still fits.
    if (strobe_ok) begin
      if (!buf_valid_q || issue) begin
        buf_valid_d = 1'b1;
        buf_d.addr  = ioctl_addr[AW-1:0];
        buf_d.we    = wr_sel;
        buf_d.data  = ioctl_dout;
      end else begin
        overflow_d = 1'b1;
      end
    end
    if ((state_q == StIdle) && active) overflow_d = 1'b0;

    if ((state_q == StAccess) && nv_ack && !cmd_q.we) din_d = nv_rdata;
    else if (oor_rd)                                  din_d = DIN_IDLE;
  end

  always_ff @(posedge clk_72) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
      cmd_q       <= '0;
      din_q       <= DIN_IDLE;
      overflow_q  <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      cmd_q       <= cmd_d;
      din_q       <= din_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_nvram_xfer_ctrl.sv
// Directed plus randomized bench for nvram_xfer_ctrl with a byte-array image model and
// behavioural NVRAM / pause responders.
module tb_nvram_xfer_ctrl;

  logic        clk_72 = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0, ioctl_downl = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic [24:0] ioctl_addr = '0;
  logic        ioctl_rd = 1'b0, ioctl_wr = 1'b0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic [7:0]  ioctl_din;
  logic        pause_req;
  logic        pause_ack = 1'b0;
  logic [9:0]  nv_addr;
  logic        nv_we;
  logic [7:0]  nv_wdata;
  logic        nv_req;
  logic        nv_ack = 1'b0;
  logic [7:0]  nv_rdata = 8'h00;
  logic        busy, overflow;

  nvram_xfer_ctrl dut (
    .clk_72      (clk_72),
    .reset       (reset),
    .ioctl_upload(ioctl_upload),
    .ioctl_downl (ioctl_downl),
    .ioctl_index (ioctl_index),
    .ioctl_addr  (ioctl_addr),
    .ioctl_rd    (ioctl_rd),
    .ioctl_wr    (ioctl_wr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_din   (ioctl_din),
    .pause_req   (pause_req),
    .pause_ack   (pause_ack),
    .nv_addr     (nv_addr),
    .nv_we       (nv_we),
    .nv_wdata    (nv_wdata),
    .nv_req      (nv_req),
    .nv_ack      (nv_ack),
    .nv_rdata    (nv_rdata),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk_72 = ~clk_72;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram     [0:1023];
  logic [7:0]  exp_mem [0:1023];
  logic [17:0] wq [$];

  int  ack_delay = 2;
  int  pause_cnt = 0;
  int  pause_hi_cnt = 0;
  int  req_cnt = 0;
  int  rsp_wait = 0;
  bit  ram_stall = 1'b0;
  bit  ack_now;
  bit  prev_req = 1'b0, prev_ack = 1'b0;
  logic [18:0] prev_cmd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_72);
      #1;
    end
  endtask

  task automatic do_rd(input logic [24:0] a);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_rd   = 1'b0;
  endtask

  task automatic do_wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
  endtask

  task automatic open_xfer(input bit upl, input logic [7:0] idx);
    ioctl_index = idx;
    if (upl) ioctl_upload = 1'b1;
    else     ioctl_downl  = 1'b1;
    for (int i = 0; i < 100 && !pause_ack; i++) tick(1);
    chk("pause_ack_seen", 32'(pause_ack), 32'd1);
    tick(1);
  endtask

  task automatic close_xfer();
    ioctl_upload = 1'b0;
    ioctl_downl  = 1'b0;
    tick(3);
  endtask

  // Core side: acknowledge pause after ack_delay cycles.
  always begin
    @(posedge clk_72);
    #1;
    if (pause_req) pause_hi_cnt++;
    if (!pause_req) begin
      pause_cnt = 0;
      pause_ack = 1'b0;
    end else if (pause_cnt >= ack_delay) begin
      pause_ack = 1'b1;
    end else begin
      pause_cnt++;
    end
  end

  // NVRAM port: random wait of 0..8 cycles, one-cycle ack, command must hold while pending.
  always begin
    @(posedge clk_72);
    #1;
    if (nv_req && prev_req && !prev_ack)
      chk("nv_cmd_stable", 32'({nv_addr, nv_we, nv_wdata}), 32'(prev_cmd));
    if (nv_req && !prev_req) req_cnt++;
    ack_now = 1'b0;
    if (nv_req && !ram_stall) begin
      if (rsp_wait == 0) begin
        if (nv_we) begin
          ram[nv_addr] = nv_wdata;
          wq.push_back({nv_addr, nv_wdata});
        end else begin
          nv_rdata = ram[nv_addr];
        end
        ack_now  = 1'b1;
        rsp_wait = $urandom_range(0, 8);
      end else begin
        rsp_wait--;
      end
    end
    nv_ack   = ack_now;
    prev_ack = ack_now;
    prev_req = nv_req;
    prev_cmd = {nv_addr, nv_we, nv_wdata};
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  logic [7:0]  t1_data [4];
  logic [24:0] rnd_addr [12];
  logic [24:0] a1, a2;
  logic [7:0]  d1, d2, rnd_d;
  int          snap;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 8'($urandom);
      exp_mem[i] = ram[i];
    end
    t1_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      ram[i]     = t1_data[i];
      exp_mem[i] = t1_data[i];
    end

    // Reset state
    tick(3);
    chk("rst_din", 32'(ioctl_din), 32'hFF);
    chk("rst_pause_req", 32'(pause_req), 32'd0);
    chk("rst_nv_req", 32'(nv_req), 32'd0);
    chk("rst_nv_cmd", 32'({nv_addr, nv_we, nv_wdata}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick(2);

    // 1: upload of first four bytes
    open_xfer(1'b1, 8'h04);
    for (int i = 0; i < 4; i++) begin
      do_rd(25'(i));
      tick(15);
      chk("t1_din", 32'(ioctl_din), 32'(t1_data[i]));
    end
    ioctl_upload = 1'b0;
    chk("t1_pause_hold", 32'(pause_req), 32'd1);
    tick(1);
    chk("t1_pause_drop", 32'(pause_req), 32'd0);
    tick(2);

    // 2: download to the top two bytes
    wq.delete();
    open_xfer(1'b0, 8'h04);
    do_wr(25'h3FE, 8'hA5);
    tick(15);
    do_wr(25'h3FF, 8'h5A);
    tick(15);
    close_xfer();
    exp_mem[10'h3FE] = 8'hA5;
    exp_mem[10'h3FF] = 8'h5A;
    chk("t2_wr_count", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk("t2_wr0", 32'(wq[0]), 32'({10'h3FE, 8'hA5}));
      chk("t2_wr1", 32'(wq[1]), 32'({10'h3FF, 8'h5A}));
    end
    chk("t2_ram_3fe", 32'(ram[10'h3FE]), 32'hA5);
    chk("t2_ram_3ff", 32'(ram[10'h3FF]), 32'h5A);

    // 3: ROM download must not touch the NVRAM path
    pause_hi_cnt = 0;
    snap = req_cnt;
    ioctl_index = 8'h00;
    ioctl_downl = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      do_wr(25'(i), 8'($urandom));
      tick(15);
    end
    close_xfer();
    chk("t3_pause_never", 32'(pause_hi_cnt), 32'd0);
    chk("t3_req_never", 32'(req_cnt), 32'(snap));

    // 4: out-of-range read returns FF without a RAM access
    ram[5] = 8'h3C;
    exp_mem[5] = 8'h3C;
    open_xfer(1'b1, 8'h04);
    do_rd(25'd5);
    tick(15);
    chk("t4_din_pre", 32'(ioctl_din), 32'h3C);
    snap = req_cnt;
    do_rd(25'h400);
    chk("t4_din_ff", 32'(ioctl_din), 32'hFF);
    tick(15);
    chk("t4_no_req", 32'(req_cnt), 32'(snap));
    close_xfer();

    // 5: pause_ack withheld; second write dropped, overflow sticky until next start
    a1 = 25'($urandom_range(0, 511));
    a2 = 25'($urandom_range(512, 1023));
    d1 = 8'($urandom);
    d2 = ~exp_mem[a2[9:0]];
    ack_delay = 40;
    wq.delete();
    ioctl_index = 8'h04;
    ioctl_downl = 1'b1;
    tick(3);
    do_wr(a1, d1);
    tick(15);
    chk("t5_ovf_before", 32'(overflow), 32'd0);
    chk("t5_busy_held", 32'(busy), 32'd1);
    do_wr(a2, d2);
    chk("t5_ovf_set", 32'(overflow), 32'd1);
    chk("t5_no_req_paused", 32'(nv_req), 32'd0);
    for (int i = 0; i < 60 && !pause_ack; i++) tick(1);
    chk("t5_pause_ack", 32'(pause_ack), 32'd1);
    tick(16);
    exp_mem[a1[9:0]] = d1;
    chk("t5_wr_count", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) chk("t5_wr0", 32'(wq[0]), 32'({a1[9:0], d1}));
    close_xfer();
    chk("t5_ovf_sticky", 32'(overflow), 32'd1);
    ack_delay = 2;
    open_xfer(1'b1, 8'h04);
    chk("t5_ovf_cleared", 32'(overflow), 32'd0);
    do_rd(a2);
    tick(15);
    chk("t5_dropped_unwritten", 32'(ioctl_din), 32'(exp_mem[a2[9:0]]));
    do_rd(a1);
    tick(15);
    chk("t5_first_written", 32'(ioctl_din), 32'(d1));
    close_xfer();

    // Randomized download/upload against the image model
    open_xfer(1'b0, 8'h04);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_addr[i] = 25'($urandom_range(1024, 4095));
      else                           rnd_addr[i] = 25'($urandom_range(0, 1023));
      rnd_d = 8'($urandom);
      do_wr(rnd_addr[i], rnd_d);
      tick(15);
      if (rnd_addr[i] < 25'd1024) exp_mem[rnd_addr[i][9:0]] = rnd_d;
    end
    close_xfer();
    open_xfer(1'b1, 8'h04);
    for (int i = 0; i < 12; i++) begin
      do_rd(rnd_addr[i]);
      tick(15);
      if (rnd_addr[i] < 25'd1024) chk("rnd_rd", 32'(ioctl_din), 32'(exp_mem[rnd_addr[i][9:0]]));
      else                        chk("rnd_rd_oor", 32'(ioctl_din), 32'hFF);
    end
    close_xfer();

    // 6: reset while an access is pending
    open_xfer(1'b1, 8'h04);
    ram_stall = 1'b1;
    do_rd(25'd7);
    for (int i = 0; i < 20 && !nv_req; i++) tick(1);
    chk("t6_req_pending", 32'(nv_req), 32'd1);
    reset = 1'b1;
    ioctl_upload = 1'b0;
    tick(1);
    chk("t6_nv_req_off", 32'(nv_req), 32'd0);
    chk("t6_pause_off", 32'(pause_req), 32'd0);
    chk("t6_din_ff", 32'(ioctl_din), 32'hFF);
    chk("t6_busy_off", 32'(busy), 32'd0);
    reset = 1'b0;
    ram_stall = 1'b0;
    rsp_wait = 0;
    tick(2);
    open_xfer(1'b1, 8'h04);
    do_rd(25'd7);
    tick(15);
    chk("t6_fresh_rd7", 32'(ioctl_din), 32'(exp_mem[7]));
    do_rd(25'h3FE);
    tick(15);
    chk("t6_fresh_rd3fe", 32'(ioctl_din), 32'(exp_mem[10'h3FE]));
    close_xfer();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
